fir_ntap_seq: RTL

- Parametrised N-tap unsigned FIR filter; successor to the fixed 3-tap, button-stepped filter.
- Uses one shared multiplier, time-multiplexed: one multiply-accumulate (MAC) per clock.
- Coefficients are reset to a parameter default and are runtime-writable.
- Samples arrive on a valid strobe, normally from the button handler's one-cycle pulse. The result is presented with a one-cycle valid pulse to the binary-to-BCD / 7-segment display path.

---
 rtl/fir_ntap_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fir_ntap_seq.sv
// Time-multiplexed N-tap unsigned FIR: one shared MAC per clock, y/y_valid land TAPS cycles after an accepted sample.
// Samples arriving while busy are dropped and set sticky overrun; define FIR_SAT_EN to saturate y instead of wrapping.
module fir_ntap_seq #(
    parameter int DATA_W = 7,
    parameter int COEF_W = 6,
    parameter int TAPS   = 3,
    parameter int OUT_W  = 14,
    parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {6'd10, 6'd15, 6'd20},
    localparam int AW    = (TAPS > 2) ? $clog2(TAPS) : 1,
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              clear,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy,
    output logic [OUT_W-1:0]  y,
    output logic              y_valid,
    output logic              overrun
);

    typedef enum logic {S_IDLE, S_MAC} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_x    [TAPS];
    logic [COEF_W-1:0] r_coef [TAPS];
    logic [ACC_W-1:0]  r_acc;
    logic [AW-1:0]     r_idx;

    logic [ACC_W-1:0]  w_prod;
    logic [ACC_W-1:0]  w_sum;
    logic [OUT_W-1:0]  w_y_next;
    logic              w_last;
    logic              w_coef_ok;

    assign w_prod    = ACC_W'(r_coef[r_idx]) * ACC_W'(r_x[r_idx]);
    assign w_sum     = r_acc + w_prod;
    assign w_last    = (r_idx == AW'(TAPS - 1));
    assign w_coef_ok = (int'(coef_addr) < TAPS);

`ifdef FIR_SAT_EN
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [EXT_W-1:0] Y_MAX = EXT_W'({OUT_W{1'b1}});

    always_comb begin
        w_y_next = OUT_W'(w_sum);
        if (EXT_W'(w_sum) > Y_MAX) begin
            w_y_next = {OUT_W{1'b1}};
        end
    end
`else
    assign w_y_next = OUT_W'(w_sum);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            busy    <= 1'b0;
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i]    <= '0;
                r_coef[i] <= COEF_INIT[i*COEF_W +: COEF_W];
            end
        end else begin
            y_valid <= 1'b0;
            if (clear) begin
                // Flush wins over everything else this cycle; y and coefficients survive.
                r_state <= S_IDLE;
                r_acc   <= '0;
                r_idx   <= '0;
                busy    <= 1'b0;
                overrun <= 1'b0;
                for (int i = 0; i < TAPS; i++) begin
                    r_x[i] <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (coef_we && w_coef_ok) begin
                            r_coef[coef_addr] <= coef_data;
                        end
                        if (sample_valid) begin
                            for (int k = TAPS - 1; k > 0; k--) begin
                                r_x[k] <= r_x[k-1];
                            end
                            r_x[0]  <= sample;
                            r_acc   <= '0;
                            r_idx   <= '0;
                            busy    <= 1'b1;
                            r_state <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        if (sample_valid) begin
                            overrun <= 1'b1;
                        end
                        r_acc <= w_sum;
                        if (w_last) begin
                            y       <= w_y_next;
                            y_valid <= 1'b1;
                            busy    <= 1'b0;
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
